// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding, reset-cause codes and cause arbitration for reset_sequencer.
// Rev 1.0
`default_nettype none

package reset_seq_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR   = 2'd0,
        CAUSE_DEBUG = 2'd1,
        CAUSE_WDOG  = 2'd2,
        CAUSE_SW    = 2'd3
    } rst_cause_e;

    // Only meaningful when at least one request is active; debug beats watchdog beats software.
    function automatic rst_cause_e pick_cause(input logic dbg, input logic wdog);
        if (dbg) begin
            return CAUSE_DEBUG;
        end else if (wdog) begin
            return CAUSE_WDOG;
        end else begin
            return CAUSE_SW;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_seq_if.sv
// reset_seq_if: request inputs and reset outputs of reset_sequencer (master = requester side).
// Rev 1.0
`default_nettype none

interface reset_seq_if;

    logic       dbg_rst_req;
    logic       sw_rst_req;
    logic       wdog_en;
    logic       wdog_kick;
    logic       rst_n_periph;
    logic       rst_n_core;
    logic [1:0] rst_cause;
    logic       seq_busy;

    modport master (
        output dbg_rst_req,
        output sw_rst_req,
        output wdog_en,
        output wdog_kick,
        input  rst_n_periph,
        input  rst_n_core,
        input  rst_cause,
        input  seq_busy
    );

    modport slave (
        input  dbg_rst_req,
        input  sw_rst_req,
        input  wdog_en,
        input  wdog_kick,
        output rst_n_periph,
        output rst_n_core,
        output rst_cause,
        output seq_busy
    );

endinterface

`default_nettype wire

// File: rtl/reset_seq_wdog.sv
// reset_seq_wdog: RUN-state watchdog; expire_o flags the edge at which the counter reaches all-ones.
// Rev 1.0
`default_nettype none

module reset_seq_wdog #(
    parameter int WDOG_WIDTH = 24
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic run_i,
    input  wire logic wdog_en_i,
    input  wire logic wdog_kick_i,
    output logic      expire_o
);

    localparam logic [WDOG_WIDTH-1:0] PRE_EXPIRE = ~(WDOG_WIDTH'(1));

    logic [WDOG_WIDTH-1:0] cnt_q;
    logic [WDOG_WIDTH-1:0] cnt_d;
    logic                  w_count;

    // A kick on the would-be expiry edge suppresses the expiry.
    assign w_count  = run_i & wdog_en_i & ~wdog_kick_i;
    assign expire_o = w_count & (cnt_q == PRE_EXPIRE);

    always_comb begin
        cnt_d = '0;
        if (w_count) begin
            cnt_d = cnt_q + WDOG_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// reset_sequencer: HOLD -> STAGGER -> RUN reset sequencer with registered, staggered reset release.
// Rev 1.0 -- watchdog built only when RESET_SEQ_WDOG_EN is defined.
`default_nettype none

module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int WDOG_WIDTH     = 24
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    reset_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rst_n_periph_q;
    logic             rst_n_core_q;
    logic [1:0]       rst_cause_q;
    logic             seq_busy_q;

    logic             w_wdog_expire;
    logic             w_run_req;
    rst_cause_e       w_run_cause;

`ifdef RESET_SEQ_WDOG_EN
    reset_seq_wdog #(
        .WDOG_WIDTH (WDOG_WIDTH)
    ) u_wdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (state_q == ST_RUN),
        .wdog_en_i   (bus.wdog_en),
        .wdog_kick_i (bus.wdog_kick),
        .expire_o    (w_wdog_expire)
    );
`else
    wire [WDOG_WIDTH-1:0] w_unused_wdog = {WDOG_WIDTH{bus.wdog_en & bus.wdog_kick}};
    assign w_wdog_expire = 1'b0;
`endif

    assign w_run_req   = bus.dbg_rst_req | w_wdog_expire | bus.sw_rst_req;
    assign w_run_cause = pick_cause(bus.dbg_rst_req, w_wdog_expire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_HOLD;
            cnt_q          <= '0;
            rst_n_periph_q <= 1'b0;
            rst_n_core_q   <= 1'b0;
            rst_cause_q    <= CAUSE_POR;
            seq_busy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (bus.dbg_rst_req) begin
                        cnt_q <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q        <= ST_STAGGER;
                        cnt_q          <= '0;
                        rst_n_periph_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STAGGER: begin
                    if (bus.dbg_rst_req) begin
                        state_q        <= ST_HOLD;
                        cnt_q          <= '0;
                        rst_n_periph_q <= 1'b0;
                        rst_n_core_q   <= 1'b0;
                        rst_cause_q    <= CAUSE_DEBUG;
                    end else if (cnt_q == STAGGER_LAST) begin
                        state_q      <= ST_RUN;
                        cnt_q        <= '0;
                        rst_n_core_q <= 1'b1;
                        seq_busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_run_req) begin
                        state_q        <= ST_HOLD;
                        cnt_q          <= '0;
                        rst_n_periph_q <= 1'b0;
                        rst_n_core_q   <= 1'b0;
                        rst_cause_q    <= w_run_cause;
                        seq_busy_q     <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a full reset hold, cause untouched.
                    state_q        <= ST_HOLD;
                    cnt_q          <= '0;
                    rst_n_periph_q <= 1'b0;
                    rst_n_core_q   <= 1'b0;
                    seq_busy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rst_n_periph = rst_n_periph_q;
    assign bus.rst_n_core   = rst_n_core_q;
    assign bus.rst_cause    = rst_cause_q;
    assign bus.seq_busy     = seq_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed vector table plus hand sequences for watchdog and async reset.
// Rev 1.0 -- watchdog sequences selected by RESET_SEQ_WDOG_EN.
`default_nettype none

module tb_reset_sequencer;

`ifdef RESET_SEQ_WDOG_EN
    localparam int TB_WDOG_W = 4;
`else
    localparam int TB_WDOG_W = 24;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reset_seq_if bus ();

    reset_sequencer #(
        .HOLD_CYCLES    (16),
        .STAGGER_CYCLES (4),
        .WDOG_WIDTH     (TB_WDOG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected vector packing: {rst_n_periph, rst_n_core, rst_cause[1:0], seq_busy}
    typedef struct {
        int         n;
        logic       dbg;
        logic       sw;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic dbg, input logic sw,
                       input logic p, input logic c, input logic [1:0] cause, input logic b);
        vec_t v;
        v.n   = n;
        v.dbg = dbg;
        v.sw  = sw;
        v.exp = {p, c, cause, b};
        tbl.push_back(v);
    endtask

    function automatic logic [4:0] outs();
        return {bus.rst_n_periph, bus.rst_n_core, bus.rst_cause, bus.seq_busy};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic dropped;
    int   first_p;
    int   first_c;

    initial begin
        bus.dbg_rst_req = 1'b0;
        bus.sw_rst_req  = 1'b0;
        bus.wdog_en     = 1'b0;
        bus.wdog_kick   = 1'b0;
        rst_n           = 1'b0;

        // POR with defaults, then software reset (incl. sw ignored in HOLD/STAGGER)
        add(15, 0, 0, 0, 0, 2'd0, 1);
        add(4,  0, 0, 1, 0, 2'd0, 1);
        add(5,  0, 0, 1, 1, 2'd0, 0);
        add(1,  0, 1, 0, 0, 2'd3, 1);
        add(5,  0, 0, 0, 0, 2'd3, 1);
        add(1,  0, 1, 0, 0, 2'd3, 1);
        add(9,  0, 0, 0, 0, 2'd3, 1);
        add(1,  0, 0, 1, 0, 2'd3, 1);
        add(1,  0, 1, 1, 0, 2'd3, 1);
        add(2,  0, 0, 1, 0, 2'd3, 1);
        add(3,  0, 0, 1, 1, 2'd3, 0);
        // Debug + software on the same edge, debug held 100 cycles
        add(1,  1, 1, 0, 0, 2'd1, 1);
        add(99, 1, 0, 0, 0, 2'd1, 1);
        add(15, 0, 0, 0, 0, 2'd1, 1);
        add(4,  0, 0, 1, 0, 2'd1, 1);
        add(2,  0, 0, 1, 1, 2'd1, 0);
        // Debug request during STAGGER returns to HOLD with cause debug
        add(1,  0, 1, 0, 0, 2'd3, 1);
        add(15, 0, 0, 0, 0, 2'd3, 1);
        add(1,  0, 0, 1, 0, 2'd3, 1);
        add(1,  1, 0, 0, 0, 2'd1, 1);
        add(15, 0, 0, 0, 0, 2'd1, 1);
        add(4,  0, 0, 1, 0, 2'd1, 1);
        add(3,  0, 0, 1, 1, 2'd1, 0);

        repeat (3) tick();
        check("reset_state", 8'(outs()), 8'(5'b00001));
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                bus.dbg_rst_req = tbl[i].dbg;
                bus.sw_rst_req  = tbl[i].sw;
                tick();
                check($sformatf("vec%0d.%0d", i, k), 8'(outs()), 8'(tbl[i].exp));
            end
        end
        bus.dbg_rst_req = 1'b0;
        bus.sw_rst_req  = 1'b0;

`ifdef RESET_SEQ_WDOG_EN
        // No kick: expiry 15 edges after RUN entry; wins over a same-edge sw request
        bus.wdog_en    = 1'b1;
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        check("wd_sw_entry", 8'(outs()), 8'(5'b00111));
        repeat (20) tick();
        check("wd_run_entry", 8'(outs()), 8'(5'b11110));
        for (int k = 1; k <= 14; k++) begin
            tick();
            check($sformatf("wd_count%0d", k), 8'(outs()), 8'(5'b11110));
        end
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        check("wd_expire_vs_sw", 8'(outs()), 8'(5'b00101));
        repeat (20) tick();
        check("wd_rerun", 8'(outs()), 8'(5'b11100));

        dropped = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            bus.wdog_kick = (c % 10 == 9);
            tick();
            if (!bus.rst_n_core) dropped = 1'b1;
        end
        bus.wdog_kick = 1'b0;
        check("wd_kick_1000", {2'b0, dropped, outs()}, {3'b0, 5'b11100});

        bus.wdog_en = 1'b0;
        tick();
        bus.wdog_en = 1'b1;
        repeat (14) tick();
        bus.wdog_kick = 1'b1;
        tick();
        bus.wdog_kick = 1'b0;
        check("wd_kick_at_expiry", 8'(outs()), 8'(5'b11100));
        repeat (14) tick();
        check("wd_pre_expiry", 8'(outs()), 8'(5'b11100));
        tick();
        check("wd_expire", 8'(outs()), 8'(5'b00101));
        bus.wdog_en = 1'b0;
`else
        bus.wdog_en = 1'b1;
        dropped     = 1'b0;
        repeat (40) begin
            tick();
            if (!bus.rst_n_core || bus.rst_cause == 2'd2) dropped = 1'b1;
        end
        bus.wdog_en = 1'b0;
        check("no_wdog", {2'b0, dropped, outs()}, {3'b0, 5'b11010});
`endif

        // Async reset while in STAGGER
        repeat (20) tick();
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        check("sw_enter_hold", 8'(outs()), 8'(5'b00111));
        repeat (16) tick();
        check("in_stagger", 8'(outs()), 8'(5'b10111));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_abort", 8'(outs()), 8'(5'b00001));
        repeat (2) tick();
        rst_n   = 1'b1;
        first_p = 0;
        first_c = 0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (bus.rst_n_periph && first_p == 0) first_p = e;
            if (bus.rst_n_core && first_c == 0) first_c = e;
        end
        check("por2_periph_edge", 8'(first_p), 8'd16);
        check("por2_core_edge", 8'(first_c), 8'd20);
        check("por2_final", 8'(outs()), 8'(5'b11000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles both resets stay asserted in HOLD (legal range 1 to 255).
REQ-002 SHALL have parameter STAGGER_CYCLES, default 4: cycles between peripheral release and core release (legal range 1 to 255).
REQ-003 SHALL have parameter WDOG_WIDTH, default 24: watchdog counter width in bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all state.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port dbg_rst_req, input, 1 bit: level request from the debug module (ndmreset); resets stay held while high.
REQ-007 SHALL have port sw_rst_req, input, 1 bit: single-cycle software reset pulse.
REQ-008 SHALL have port wdog_en, input, 1 bit: level enable for the watchdog.
REQ-009 SHALL have port wdog_kick, input, 1 bit: pulse that clears the watchdog counter.
REQ-010 SHALL have port rst_n_periph, output, 1 bit: registered, active-low peripheral/bus reset.
REQ-011 SHALL have port rst_n_core, output, 1 bit: registered, active-low processor reset.
REQ-012 SHALL have port rst_cause, output, 2 bits: last reset cause; 0 = POR, 1 = debug, 2 = watchdog, 3 = software.
REQ-013 SHALL have port seq_busy, output, 1 bit: high in any state other than RUN.

Function
REQ-014 SHALL implement three states.
- HOLD: both resets asserted; cycle counter increments.
- STAGGER: rst_n_periph = 1, rst_n_core = 0.
- RUN: both resets released.
REQ-015 HOLD -> STAGGER SHALL occur at the edge where the counter reaches HOLD_CYCLES-1 and dbg_rst_req = 0; the counter is cleared on that edge.
REQ-016 While dbg_rst_req = 1 in HOLD, the counter SHALL be held at 0.
REQ-017 STAGGER -> RUN SHALL occur at the edge where the counter reaches STAGGER_CYCLES-1.
REQ-018 dbg_rst_req = 1 in STAGGER SHALL return the block to HOLD with rst_cause = 1 on the next edge.
REQ-019 In RUN, dbg_rst_req, watchdog expiry, or sw_rst_req SHALL cause entry to HOLD on the next edge.
- Both resets are low after that edge (one-cycle latency).
- rst_cause is latched on the same edge.
REQ-020 Simultaneous reset requests SHALL be prioritised debug > watchdog > software; rst_cause reports only the winner.
REQ-021 sw_rst_req SHALL be ignored in HOLD and STAGGER.
REQ-022 rst_cause SHALL be updated only on entry to HOLD from RUN or STAGGER, and SHALL stay stable otherwise.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-024 The state register SHALL use safe decoding: any unreachable encoding goes to HOLD.

Reset
REQ-025 While rst_n = 0, the block SHALL be in HOLD with counter = 0, watchdog = 0, rst_n_periph = 0, rst_n_core = 0, rst_cause = 0, and seq_busy = 1.
REQ-026 Assertion of rst_n mid-sequence SHALL abort the sequence immediately and asynchronously; the POR sequence restarts on release.
REQ-027 After rst_n deasserts, rst_n_periph SHALL rise at rising edge HOLD_CYCLES and rst_n_core SHALL rise at edge HOLD_CYCLES+STAGGER_CYCLES (default: edges 16 and 20).

Configuration
REQ-028 Macro RESET_SEQ_WDOG_EN SHALL control the watchdog.
- Defined: the watchdog counter increments each RUN cycle while wdog_en = 1.
- It is cleared by wdog_kick, by wdog_en = 0, and in HOLD and STAGGER.
- Expiry is the edge at which it reaches all-ones; wdog_kick on that same edge wins, and no reset occurs.
- Undefined: no watchdog flops exist, wdog_en and wdog_kick are ignored, and rst_cause never reads 2.

Structure
REQ-029 Package reset_seq_pkg SHALL hold the state encoding (HOLD = 0, STAGGER = 1, RUN = 2) and the rst_cause code constants.
REQ-030 The watchdog SHALL be a sub-module reset_seq_wdog, instantiated only under RESET_SEQ_WDOG_EN; the sequencer FSM stays in the top module.

Verification
REQ-031 SHALL cover POR with defaults: release rst_n -> rst_n_periph = 1 at edge 16, rst_n_core = 1 at edge 20, rst_cause = 0, seq_busy = 0 from edge 20.
REQ-032 SHALL cover software reset: in RUN, 1-cycle sw_rst_req -> both resets low next edge, rst_cause = 3, core released again 20 edges later.
REQ-033 SHALL cover debug hold: dbg_rst_req high for 100 cycles from RUN -> resets stay low throughout; rst_n_periph rises 16 edges after dbg_rst_req falls; rst_cause = 1.
REQ-034 SHALL cover simultaneous requests: dbg_rst_req and sw_rst_req on the same edge -> rst_cause = 1; sw_rst_req during STAGGER -> no effect.
REQ-035 SHALL cover the watchdog (RESET_SEQ_WDOG_EN, WDOG_WIDTH = 4, wdog_en = 1):
- No kick -> reset 15 edges after RUN entry, rst_cause = 2.
- Kick every 10 cycles -> no reset for 1000 cycles.
REQ-036 SHALL cover mid-sequence reset: assert rst_n during STAGGER -> all outputs at reset values immediately, without waiting for a clock edge.
